// File: rtl/msrv32_fetch_buffer.sv
// Instruction fetch buffer: first-word-fall-through queue of {pc, instr} pairs
// between the instruction-memory response port and decode, cleared on flush.
module msrv32_fetch_buffer #(
  parameter int unsigned DEPTH     = 4,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
  input  logic                    ms_riscv32_mp_clk_in,
  input  logic                    ms_riscv32_mp_rst_in,
  input  logic                    flush_in,
  input  logic                    imem_valid_in,
  input  logic [31:0]             imem_instr_in,
  input  logic [31:0]             imem_pc_in,
  output logic                    imem_ready_out,
  output logic                    dec_valid_out,
  input  logic                    dec_ready_in,
  output logic [31:0]             instr_out,
  output logic [31:0]             pc_out,
  output logic                    illegal_out,
  output logic [$clog2(DEPTH):0]  count_out
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);
  localparam logic [AW:0] LAST_CNT = (AW+1)'(DEPTH - 1);
  localparam logic [AW:0] ONE_CNT  = (AW+1)'(1);

  typedef enum logic [1:0] {S_EMPTY, S_PARTIAL, S_FULL} state_t;

  state_t          state;
  logic [AW:0]     cnt;
  logic [AW-1:0]   wp;
  logic [AW-1:0]   rp;
  logic [31:0]     mem_pc    [DEPTH];
  logic [31:0]     mem_instr [DEPTH];
  logic            push;
  logic            pop;

  // Ready is derived from occupancy only, so decode never reaches memory combinationally.
  assign imem_ready_out = (state != S_FULL) && !flush_in;
  assign dec_valid_out  = (state != S_EMPTY) && !flush_in;
  assign push           = imem_valid_in && imem_ready_out;
  assign pop            = dec_valid_out && dec_ready_in;
  assign count_out      = cnt;

  always_comb begin
    instr_out   = NOP_INSTR;
    pc_out      = '0;
    illegal_out = 1'b0;
    if (state != S_EMPTY) begin
      instr_out   = mem_instr[rp];
      pc_out      = mem_pc[rp];
      illegal_out = dec_valid_out && (mem_instr[rp][1:0] != 2'b11);
    end
  end

  // Storage has no reset; contents are only visible through a valid occupancy.
  always_ff @(posedge ms_riscv32_mp_clk_in) begin
    if (push) begin
      mem_pc[wp]    <= imem_pc_in;
      mem_instr[wp] <= imem_instr_in;
    end
  end

  always_ff @(posedge ms_riscv32_mp_clk_in) begin
    if (ms_riscv32_mp_rst_in || flush_in) begin
      state <= S_EMPTY;
      cnt   <= '0;
      wp    <= '0;
      rp    <= '0;
    end else begin
      if (push) wp <= wp + 1'b1;
      if (pop)  rp <= rp + 1'b1;
      case ({push, pop})
        2'b10: begin
          cnt   <= cnt + 1'b1;
          state <= (cnt == LAST_CNT) ? S_FULL : S_PARTIAL;
        end
        2'b01: begin
          cnt   <= cnt - 1'b1;
          state <= (cnt == ONE_CNT) ? S_EMPTY : S_PARTIAL;
        end
        default: begin
          cnt   <= cnt;
          state <= (cnt == FULL_CNT) ? S_FULL : state;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_msrv32_fetch_buffer.sv
// Scoreboard bench for msrv32_fetch_buffer: a queue model of the buffer is
// filled from the stimulus side and drained by a negedge monitor.
module tb_msrv32_fetch_buffer;

  localparam int unsigned DEPTH = 4;
  localparam logic [31:0] NOP   = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rst, flush, v_in, rdy;
  logic [31:0] instr_in, pc_in;
  logic        imem_ready, dec_valid, illegal;
  logic [31:0] instr_o, pc_o;
  logic [2:0]  count_o;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } ent_t;

  ent_t        q[$];
  bit          full_now = 0;
  int unsigned total = 0;
  int unsigned bad   = 0;

  msrv32_fetch_buffer #(.DEPTH(DEPTH), .NOP_INSTR(NOP)) dut (
    .ms_riscv32_mp_clk_in (clk),
    .ms_riscv32_mp_rst_in (rst),
    .flush_in             (flush),
    .imem_valid_in        (v_in),
    .imem_instr_in        (instr_in),
    .imem_pc_in           (pc_in),
    .imem_ready_out       (imem_ready),
    .dec_valid_out        (dec_valid),
    .dec_ready_in         (rdy),
    .instr_out            (instr_o),
    .pc_out               (pc_o),
    .illegal_out          (illegal),
    .count_out            (count_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Stimulus side of the scoreboard: an accepted memory response becomes an expected entry.
  always @(posedge clk) begin
    if (rst || flush) q.delete();
    else if (v_in && !full_now) q.push_back('{pc: pc_in, instr: instr_in});
  end

  // Monitor: compare every non-reset cycle, retire the head when decode takes it.
  always @(negedge clk) begin
    int unsigned sz;
    bit          exp_v;
    ent_t        h;
    sz       = q.size();
    full_now = (sz == DEPTH);
    if (!rst) begin
      exp_v = (sz != 0) && !flush;
      chk("dec_valid", {31'b0, dec_valid}, {31'b0, exp_v});
      chk("imem_ready", {31'b0, imem_ready}, {31'b0, (sz != DEPTH) && !flush});
      chk("count", {29'b0, count_o}, sz);
      if (sz == 0) begin
        chk("instr_empty", instr_o, NOP);
        chk("pc_empty", pc_o, 32'h0);
        chk("illegal_empty", {31'b0, illegal}, 32'h0);
      end else begin
        h = q[0];
        chk("instr_head", instr_o, h.instr);
        chk("pc_head", pc_o, h.pc);
        chk("illegal_head", {31'b0, illegal}, {31'b0, exp_v && (h.instr[1:0] != 2'b11)});
        if (exp_v && rdy) void'(q.pop_front());
      end
    end
  end

  task automatic drive(input logic r, input logic f, input logic v,
                       input logic [31:0] pc, input logic [31:0] ins, input logic d);
    rst = r; flush = f; v_in = v; pc_in = pc; instr_in = ins; rdy = d;
    @(posedge clk);
    #1;
  endtask

  logic [31:0] prog [4];
  logic [31:0] rpc;
  logic [31:0] rins;

  initial begin
    prog[0] = 32'h0050_0093; prog[1] = 32'h00A0_0113;
    prog[2] = 32'h0020_81B3; prog[3] = 32'h0000_0013;

    drive(1, 0, 0, 0, 0, 0);
    drive(1, 0, 0, 0, 0, 0);
    drive(0, 0, 0, 0, 0, 0);

    // Fill, hold full, offer a response while full and popping, then drain.
    for (int i = 0; i < 4; i++) drive(0, 0, 1, 32'(i * 4), prog[i], 0);
    drive(0, 0, 0, 0, 0, 0);
    drive(0, 0, 1, 32'h10, 32'h0000_0093, 1);
    for (int i = 0; i < 3; i++) drive(0, 0, 0, 0, 0, 1);
    drive(0, 0, 0, 0, 0, 1);

    // Streaming from empty; pointers wrap several times.
    for (int i = 0; i < 20; i++) drive(0, 0, 1, 32'h200 + 32'(i * 4), 32'h0010_0093 + 32'(i << 20), 1);
    drive(0, 0, 0, 0, 0, 1);
    drive(0, 0, 0, 0, 0, 1);

    // Flush with three entries buffered while memory keeps responding.
    for (int i = 0; i < 3; i++) drive(0, 0, 1, 32'h40 + 32'(i * 4), 32'h0000_0013, 0);
    drive(0, 1, 1, 32'h1F0, 32'h0000_0093, 1);
    drive(0, 0, 1, 32'h100, 32'h0030_0193, 0);
    drive(0, 0, 0, 0, 0, 0);
    drive(0, 0, 0, 0, 0, 1);

    // Non-32-bit encoding at the head, then a legal one.
    drive(0, 0, 1, 32'h300, 32'h0000_0000, 0);
    drive(0, 0, 1, 32'h304, 32'h0000_0013, 0);
    drive(0, 0, 0, 0, 0, 1);
    drive(0, 0, 0, 0, 0, 1);
    drive(0, 0, 0, 0, 0, 1);

    // Reset while full with decode ready: nothing retires, buffer empties.
    for (int i = 0; i < 4; i++) drive(0, 0, 1, 32'h400 + 32'(i * 4), prog[i], 0);
    drive(1, 0, 1, 32'h410, 32'h0000_0013, 1);
    drive(0, 0, 0, 0, 0, 1);
    drive(0, 0, 0, 0, 0, 0);

    rpc = 32'h1000;
    for (int i = 0; i < 400; i++) begin
      rins = $urandom;
      if ($urandom_range(0, 3) != 0) rins[1:0] = 2'b11;
      drive($urandom_range(0, 99) < 2, $urandom_range(0, 99) < 5,
            $urandom_range(0, 9) < 7, rpc, rins, $urandom_range(0, 9) < 5);
      rpc = rpc + 32'h4;
    end

    drive(0, 0, 0, 0, 0, 1);
    drive(0, 0, 0, 0, 0, 1);
    drive(0, 0, 0, 0, 0, 1);
    drive(0, 0, 0, 0, 0, 1);
    drive(0, 0, 0, 0, 0, 0);
    @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
